// File: rtl/cu_pkg.sv
// Shared types for the parameterised control unit: FSM states, opcodes and
// a couple of small decode helpers used by the top level.
package cu_pkg;

  // Width of the opcode field at the top of every instruction word.
  localparam int OP_W = 3;

  // Sequencer states; T1..T3 are the execution steps after capture.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_e;

  // Instruction opcodes; the two top codes are reserved and trap as illegal.
  typedef enum logic [OP_W-1:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_MVNZ = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_e;

  // ALU operations take the long T1 -> T2 -> T3 path through the sequencer.
  function automatic logic is_alu_op(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
  endfunction

  // Register-index width for a given register count (at least one bit).
  function automatic int ridx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage : cu_pkg

// File: rtl/reg_onehot_decoder.sv
// Converts a register index into a one-hot strobe vector. With en low, or an
// index beyond the register count, every strobe stays low.
module reg_onehot_decoder #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  // Compare the index against every register number; at most one bit matches.
  always_comb begin
    // NOTE: a default before any conditional write keeps this purely
    // combinational; a missing default on some path would infer a latch.
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule : reg_onehot_decoder

// File: rtl/param_control_unit.sv
// Multi-cycle control unit for a small register-file datapath. It captures an
// instruction into IR, then steps through up to three execution states,
// raising the register, accumulator and ALU strobes for each step.
module param_control_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int IMM_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_instr,
  input  logic [DATA_W-1:0]   instr,
  input  logic                g_zero,
  output logic                instr_ctrl,
  output logic [NUM_REGS-1:0] rin,
  output logic [NUM_REGS-1:0] rout,
  output logic                a_in,
  output logic                gin,
  output logic                gout,
  output logic                addsub,
  output logic                xorctrl,
  output logic                ctrl_out,
  output logic [DATA_W-1:0]   out,
  output logic                pc_inc,
  output logic                done,
  output logic                busy,
  output logic                illegal
);

  import cu_pkg::*;

  localparam int RIDX_W = ridx_width(NUM_REGS);

  // Field positions: opcode at the top, then rx, then ry; immediate at the bottom.
  localparam int RX_MSB = DATA_W - OP_W - 1;
  localparam int RY_MSB = RX_MSB - RIDX_W;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                instr_ctrl_q, instr_ctrl_d;

  opcode_e             op;
  logic [RIDX_W-1:0]   rx;
  logic [RIDX_W-1:0]   ry;

  logic                rin_en;
  logic                rout_en;
  logic [RIDX_W-1:0]   rout_idx;

  // Every IR bit feeds either the field decode or the immediate; this fold
  // just keeps the unused gap bits (for wide DATA_W) from being flagged.
  logic                unused_ir;
  assign unused_ir = ^ir_q;

  assign op = opcode_e'(ir_q[DATA_W-1 -: OP_W]);
  assign rx = ir_q[RX_MSB -: RIDX_W];
  assign ry = ir_q[RY_MSB -: RIDX_W];

  // Immediate is visible on the bus port continuously, zero-extended.
  assign out = DATA_W'(ir_q[IMM_W-1:0]);

  assign busy       = (state_q != ST_IDLE);
  assign instr_ctrl = instr_ctrl_q;

  // Next-state and IR-capture logic; new_instr is only honoured in IDLE.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    instr_ctrl_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (new_instr) begin
          ir_d         = instr;
          instr_ctrl_d = 1'b1;
          state_d      = ST_T1;
        end
      end
      ST_T1:   state_d = is_alu_op(op) ? ST_T2 : ST_IDLE;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, IR and the IR-load pulse; reset clears all of them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ir_q         <= '0;
      instr_ctrl_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, regardless of statement order.
      state_q      <= state_d;
      ir_q         <= ir_d;
      instr_ctrl_q <= instr_ctrl_d;
    end
  end

  // Step decode: strobes depend only on the registered state and IR (plus
  // g_zero for the conditional move), so they are glitch-free per cycle.
  always_comb begin
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = rx;
    a_in     = 1'b0;
    gin      = 1'b0;
    gout     = 1'b0;
    addsub   = 1'b0;
    xorctrl  = 1'b0;
    ctrl_out = 1'b0;
    pc_inc   = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      ST_T1: begin
        case (op)
          OP_MV: begin
            rout_en  = 1'b1;
            rout_idx = ry;
            rin_en   = 1'b1;
            done     = 1'b1;
            pc_inc   = 1'b1;
          end
          OP_MVI: begin
            ctrl_out = 1'b1;
            rin_en   = 1'b1;
            done     = 1'b1;
            pc_inc   = 1'b1;
          end
          OP_MVNZ: begin
            done   = 1'b1;
            pc_inc = 1'b1;
            if (!g_zero) begin
              rout_en  = 1'b1;
              rout_idx = ry;
              rin_en   = 1'b1;
            end
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            rout_en  = 1'b1;
            rout_idx = rx;
            a_in     = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            done    = 1'b1;
            pc_inc  = 1'b1;
          end
        endcase
      end
      ST_T2: begin
        rout_en  = 1'b1;
        rout_idx = ry;
        gin      = 1'b1;
        addsub   = (op == OP_SUB);
        xorctrl  = (op == OP_XOR);
      end
      ST_T3: begin
        gout   = 1'b1;
        rin_en = 1'b1;
        done   = 1'b1;
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

  // Destination register load strobe; the destination is always rx.
  reg_onehot_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (RIDX_W)
  ) u_rin_dec (
    .en     (rin_en),
    .idx    (rx),
    .onehot (rin)
  );

  // Source register bus-drive strobe; rx or ry depending on the step.
  reg_onehot_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (RIDX_W)
  ) u_rout_dec (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (rout)
  );

endmodule : param_control_unit

// File: doc/param_control_unit.md
PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: instruction and bus width.
REQ-002 SHALL have parameter NUM_REGS, default 8: register count; RIDX_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter IMM_W, default 8: immediate field width; legal when 3+RIDX_W+IMM_W <= DATA_W and 3+2*RIDX_W <= DATA_W.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 new_instr  in  1  instruction-valid strobe.
REQ-007 instr  in  DATA_W  instruction word.
REQ-008 g_zero  in  1  high when the G register equals zero.
REQ-009 instr_ctrl  out  1  IR-load pulse.
REQ-010 rin, rout  out  NUM_REGS each  one-hot register load and bus-drive strobes.
REQ-011 a_in, gin, gout  out  1 each  A load, G load, G bus-drive.
REQ-012 addsub, xorctrl  out  1 each  ALU mode: 1 = subtract; 1 = XOR.
REQ-013 ctrl_out  out  1  immediate drives bus.
REQ-014 out  out  DATA_W  zero-extended immediate.
REQ-015 pc_inc, done  out  1 each  program-counter advance pulse; completion pulse.
REQ-016 busy, illegal  out  1 each  busy = not IDLE; illegal = illegal-opcode pulse.

Function
REQ-017 Field layout: op = IR[DATA_W-1 -: 3], rx = next RIDX_W bits, ry = next RIDX_W bits, imm = IR[IMM_W-1:0].
REQ-018 Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 xor, 101 mvnz, 110/111 illegal.
REQ-019 States: IDLE, T1, T2, T3, registered.
REQ-020 IDLE with new_instr=1: capture instr into IR, instr_ctrl=1 that cycle, next state T1; new_instr=0 keeps IDLE.
REQ-021 new_instr SHALL be ignored while busy=1; IR is held.
REQ-022 T1, mv: rout[ry]=1, rin[rx]=1, done=1, pc_inc=1, then IDLE.
REQ-023 T1, mvi: ctrl_out=1, rin[rx]=1, done=1, pc_inc=1, then IDLE.
REQ-024 T1, mvnz: as mv when g_zero=0; when g_zero=1, only done=1 and pc_inc=1, then IDLE.
REQ-025 T1, add/sub/xor: rout[rx]=1, a_in=1, then T2.
REQ-026 T2: rout[ry]=1, gin=1; addsub=1 only for sub, xorctrl=1 only for xor; then T3.
REQ-027 T3: gout=1, rin[rx]=1, done=1, pc_inc=1, then IDLE.
REQ-028 T1, illegal opcode: illegal=1, done=1, pc_inc=1, no register, A or G strobe, then IDLE.
REQ-029 out SHALL equal the zero-extended IR[IMM_W-1:0] at all times.
REQ-030 All strobes SHALL be decoded from registered state and IR only, and are 0 unless stated.
REQ-031 rin and rout SHALL each have at most one bit set; rx == ry SHALL be legal.
REQ-032 Latency from capture to done: 1 cycle for mv/mvi/mvnz/illegal, 3 cycles for ALU ops.
REQ-033 A new instruction SHALL be accepted in the cycle after done (back-to-back).

Reset
REQ-034 rst=0 SHALL force IDLE and IR=0 immediately, asynchronously to clk, including mid-instruction.
REQ-035 During reset, every output SHALL be 0 (out = 0).
REQ-036 The first rising edge after rst goes high SHALL sample new_instr normally.

Structure
REQ-037 Package cu_pkg SHALL hold the state enum and the opcode constants.
REQ-038 Sub-module reg_onehot_decoder (index to NUM_REGS-bit one-hot, with enable) SHALL be instantiated once for rin and once for rout.
REQ-039 State register and IR SHALL reside in param_control_unit.

Verification (defaults)
REQ-040 mvi r3,#A5: instr=16'h2CA5 in IDLE -> instr_ctrl next edge; T1: ctrl_out=1, rin=8'h08, out=16'h00A5, done=1.
REQ-041 add r1,r2: instr=16'h4500 -> T1 rout=8'h02, a_in; T2 rout=8'h04, gin, addsub=0, xorctrl=0; T3 gout, rin=8'h02, done.
REQ-042 sub r4,r5: instr=16'h7280 -> T2 addsub=1; then mv r7,r0 (16'h1C00) presented in the done cycle is captured next cycle, T1 rout=8'h01, rin=8'h80.
REQ-043 mvnz r2,r6: instr=16'hAB00 with g_zero=1 -> T1 done=1, rin=0; with g_zero=0 -> rout=8'h40, rin=8'h04.
REQ-044 Illegal opcode: instr=16'hE000 -> T1 illegal=1, done=1, rin=rout=0, a_in=gin=0.
REQ-045 rst=0 asserted in T2 of add -> all outputs 0 at once, busy=0; new_instr=1 held during T2 is never captured.
